// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uartTX serializer between N_SRC FWFT source FIFOs.
// Each grant sends an optional channel-ID header byte followed by up to MAX_BURST payload bytes.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | no grant; picks the next requesting source after last_grant
// ST_HEADER | presenting {HEADER_TAG, grantId} to uartTX
// ST_BURST  | passing the granted source's head byte and pops through
module uart_tx_arbiter #(
    parameter int          N_SRC      = 4,
    parameter int          MAX_BURST  = 16,
    parameter bit          HEADER_EN  = 1'b1,
    parameter logic [3:0]  HEADER_TAG = 4'hA,
    localparam int         ID_W       = $clog2(N_SRC),
    localparam int         CNT_W      = $clog2(MAX_BURST + 1)
) (
    input  logic                 CLK288MHZ,
    input  logic                 reset,
    input  logic [8*N_SRC-1:0]   srcData,
    input  logic [N_SRC-1:0]     srcNE,
    output logic [N_SRC-1:0]     srcReadEn,
    output logic [7:0]           txData,
    output logic                 txNE,
    input  logic                 txReadEn,
    output logic [ID_W-1:0]      grantId,
    output logic                 busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HEADER = 2'd1;
    localparam logic [1:0] ST_BURST  = 2'd2;

    logic [1:0]       state;
    logic [ID_W-1:0]  last_grant;
    logic [ID_W-1:0]  next_grant;
    logic [ID_W-1:0]  rr_idx;
    logic [CNT_W-1:0] burst_cnt;
    logic             req_any;
    logic             cur_ne;
    logic             pop;
    logic             burst_done;
    logic [7:0]       src_byte [N_SRC];

    for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
        assign src_byte[i] = srcData[8*i +: 8];
    end

    // Search starts one past the last grant so every source gets a turn.
    always_comb begin
        next_grant = last_grant;
        req_any    = 1'b0;
        rr_idx     = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            rr_idx = ID_W'((int'(last_grant) + k) % N_SRC);
            if (!req_any && srcNE[rr_idx]) begin
                req_any    = 1'b1;
                next_grant = rr_idx;
            end
        end
    end

    assign cur_ne     = srcNE[grantId];
    assign pop        = (state == ST_BURST) && txReadEn;
    assign burst_done = pop && (burst_cnt == CNT_W'(MAX_BURST - 1));

    always_ff @(posedge CLK288MHZ or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            grantId    <= '0;
            last_grant <= ID_W'(N_SRC - 1);
            burst_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_any) begin
                        grantId    <= next_grant;
                        last_grant <= next_grant;
                        burst_cnt  <= '0;
                        state      <= HEADER_EN ? ST_HEADER : ST_BURST;
                    end
                end
                ST_HEADER: begin
                    if (txReadEn) begin
                        state <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (pop) begin
                        burst_cnt <= burst_cnt + CNT_W'(1);
                    end
                    // Leave on the final allowed pop, or when the source runs dry with nothing in flight.
                    if (burst_done || (!cur_ne && !pop)) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        txData    = 8'h00;
        txNE      = 1'b0;
        srcReadEn = '0;
        case (state)
            ST_HEADER: begin
                txData = {HEADER_TAG, 4'(grantId)};
                txNE   = 1'b1;
            end
            ST_BURST: begin
                txData             = src_byte[grantId];
                txNE               = cur_ne;
                srcReadEn[grantId] = txReadEn;
            end
            default: ;
        endcase
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-based source FIFOs, a randomly paced uartTX pop model,
// and a transaction-level model that predicts the full transmitted byte stream.
module tb_uart_tx_arbiter;

    localparam int         N   = 4;
    localparam int         MB  = 16;
    localparam bit         HE  = 1'b1;
    localparam logic [3:0] TAG = 4'hA;

    logic           CLK288MHZ = 1'b0;
    logic           reset     = 1'b0;
    logic [8*N-1:0] srcData   = '0;
    logic [N-1:0]   srcNE     = '0;
    logic [N-1:0]   srcReadEn;
    logic [7:0]     txData;
    logic           txNE;
    logic           txReadEn  = 1'b0;
    logic [1:0]     grantId;
    logic           busy;

    uart_tx_arbiter #(
        .N_SRC(N), .MAX_BURST(MB), .HEADER_EN(HE), .HEADER_TAG(TAG)
    ) dut (
        .CLK288MHZ(CLK288MHZ), .reset(reset), .srcData(srcData), .srcNE(srcNE),
        .srcReadEn(srcReadEn), .txData(txData), .txNE(txNE), .txReadEn(txReadEn),
        .grantId(grantId), .busy(busy)
    );

    always #5 CLK288MHZ = ~CLK288MHZ;

    typedef struct {
        logic [7:0] b;
        int         src;
        bit         hdr;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] q[N][$];
    logic [N-1:0] pend = '0;
    int         m_last = N - 1;
    logic [7:0] obs[$];
    int         grants[$];
    int         blen[$];
    int         rd_cnt[N];
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic drive_sources();
        for (int i = 0; i < N; i++) begin
            srcNE[i]          = (q[i].size() != 0);
            srcData[8*i +: 8] = (q[i].size() != 0) ? q[i][0] : 8'h00;
        end
    endtask

    // One clock: retire last cycle's pops, refresh FIFO heads, then decide this cycle's pop.
    task automatic step(input bit want_pop);
        @(posedge CLK288MHZ);
        #1;
        for (int i = 0; i < N; i++) begin
            if (pend[i] && q[i].size() != 0) q[i].delete(0);
        end
        drive_sources();
        #1;
        txReadEn = want_pop && txNE;
        #1;
        pend = srcReadEn;
    endtask

    // Whole-stream prediction: sources only drain, so the grant sequence follows from the counts.
    task automatic build_exp();
        int   rem[N];
        int   pos[N];
        int   last;
        int   s;
        int   n;
        bit   any;
        bit   found;
        exp_t e;
        last = m_last;
        for (int i = 0; i < N; i++) begin
            rem[i] = q[i].size();
            pos[i] = 0;
        end
        any = 1'b1;
        while (any) begin
            any = 1'b0;
            for (int i = 0; i < N; i++) if (rem[i] > 0) any = 1'b1;
            if (any) begin
                s = last;
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    if (!found && rem[(last + k) % N] > 0) begin
                        s = (last + k) % N;
                        found = 1'b1;
                    end
                end
                if (HE) begin
                    e.b = {TAG, 4'(s)}; e.src = s; e.hdr = 1'b1;
                    exp_q.push_back(e);
                end
                n = (rem[s] < MB) ? rem[s] : MB;
                for (int j = 0; j < n; j++) begin
                    e.b = q[s][pos[s] + j]; e.src = s; e.hdr = 1'b0;
                    exp_q.push_back(e);
                end
                pos[s] += n;
                rem[s] -= n;
                last = s;
            end
        end
        m_last = last;
    endtask

    task automatic run_traffic(input int max_cyc);
        int           cyc;
        bit           done;
        bit           pend_req;
        bit           prev_busy;
        logic [N-1:0] exp_rd;
        obs.delete(); grants.delete(); blen.delete(); exp_q.delete();
        for (int i = 0; i < N; i++) rd_cnt[i] = 0;
        build_exp();
        cyc = 0; done = 1'b0; pend_req = 1'b0; prev_busy = busy;
        while (!done && cyc < max_cyc) begin
            step($urandom_range(0, 2) != 0);
            cyc++;
            if (pend_req) chk("gap_busy", busy, 1);
            pend_req = !busy && (srcNE != '0);
            if (!busy) chk("idle_txne", txNE, 0);
            if (busy && !prev_busy) begin
                grants.push_back(int'(grantId));
                blen.push_back(0);
            end
            prev_busy = busy;
            exp_rd = '0;
            if (txNE) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL extra_byte: got %0h, expected no byte", txData);
                end else begin
                    chk("tx_data", txData, exp_q[0].b);
                    chk("grant_id", grantId, exp_q[0].src);
                    if (txReadEn && !exp_q[0].hdr) exp_rd[exp_q[0].src] = 1'b1;
                end
            end
            chk("src_read_en", srcReadEn, exp_rd);
            if (txReadEn && txNE && exp_q.size() != 0) begin
                obs.push_back(txData);
                exp_q.delete(0);
            end
            for (int i = 0; i < N; i++) if (srcReadEn[i]) rd_cnt[i]++;
            if (srcReadEn != '0 && blen.size() != 0) blen[blen.size()-1]++;
            done = (exp_q.size() == 0) && !busy;
        end
        txReadEn = 1'b0;
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL traffic_timeout: got %0d bytes left, expected 0", exp_q.size());
        end
    endtask

    initial begin
        int cnt;
        int nb;

        #1 reset = 1'b1;
        #11;
        chk("rst_txne", txNE, 0);
        chk("rst_txdata", txData, 8'h00);
        chk("rst_rden", srcReadEn, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grantId, 0);
        reset = 1'b0;

        // All four sources with 40 bytes: three rounds of 16,16,8 starting at source 0.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < 40; j++) q[i].push_back(8'(i*64 + j));
        run_traffic(4000);
        chk("rr_bytes", obs.size(), 172);
        chk("rr_grants", grants.size(), 12);
        if (grants.size() == 12) begin
            for (int j = 0; j < 12; j++) begin
                chk("rr_order", grants[j], j % 4);
                chk("rr_burst_len", blen[j], (j < 8) ? 16 : 8);
            end
        end

        // Last grant is 3; sources 1 and 3 requesting gives 1 then 3.
        q[1].push_back(8'h31); q[1].push_back(8'h32); q[3].push_back(8'h71);
        run_traffic(500);
        chk("wrap_grants", grants.size(), 2);
        if (grants.size() == 2) begin
            chk("wrap_first", grants[0], 1);
            chk("wrap_second", grants[1], 3);
        end

        q[2].push_back(8'h11); q[2].push_back(8'h22); q[2].push_back(8'h33);
        run_traffic(500);
        chk("single_len", obs.size(), 4);
        if (obs.size() == 4) begin
            chk("single_b0", obs[0], 8'hA2);
            chk("single_b1", obs[1], 8'h11);
            chk("single_b2", obs[2], 8'h22);
            chk("single_b3", obs[3], 8'h33);
        end
        chk("single_pops", rd_cnt[2], 3);
        chk("single_other_pops", rd_cnt[0] + rd_cnt[1] + rd_cnt[3], 0);
        chk("single_busy", busy, 0);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) begin
                nb = $urandom_range(0, 24);
                for (int j = 0; j < nb; j++) q[i].push_back(8'($urandom));
            end
            run_traffic(6000);
        end

        // Source 0 empties while its header is pending.
        pend = '0;
        q[0].push_back(8'h5C);
        cnt = 0;
        step(1'b0);
        while (!txNE && cnt < 6) begin
            step(1'b0);
            cnt++;
        end
        chk("hdr_wait_txne", txNE, 1);
        chk("hdr_byte", txData, 8'hA0);
        q[0].delete();
        step(1'b0);
        chk("hdr_held_txne", txNE, 1);
        chk("hdr_held_byte", txData, 8'hA0);
        step(1'b1);
        chk("hdr_pop_rden", srcReadEn, 0);
        step(1'b0);
        chk("hdr_empty_txne", txNE, 0);
        chk("hdr_empty_rden", srcReadEn, 0);
        step(1'b0);
        chk("hdr_return_idle", busy, 0);
        m_last = 0;

        // Reset after five payload pops of a sixteen-byte burst.
        for (int j = 0; j < 20; j++) q[1].push_back(8'(8'h40 + j));
        cnt = 0;
        for (int c = 0; c < 60 && cnt < 5; c++) begin
            step(1'b1);
            if (srcReadEn != '0) cnt++;
        end
        chk("pre_reset_pops", cnt, 5);
        chk("pre_reset_busy", busy, 1);
        @(posedge CLK288MHZ);
        #1 txReadEn = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("midrst_txne", txNE, 0);
        chk("midrst_rden", srcReadEn, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_grant", grantId, 0);
        for (int i = 0; i < N; i++) q[i].delete();
        pend = '0;
        drive_sources();
        @(posedge CLK288MHZ);
        #2 reset = 1'b0;
        m_last = N - 1;
        q[3].push_back(8'h77); q[3].push_back(8'h78);
        run_traffic(500);
        chk("post_rst_len", obs.size(), 3);
        if (obs.size() != 0) chk("post_rst_hdr", obs[0], 8'hA3);

        // Sources 0 and 2 after the A3 grant: 0 comes before 2.
        q[0].push_back(8'h01); q[2].push_back(8'h02);
        run_traffic(500);
        chk("after_rst_grants", grants.size(), 2);
        if (grants.size() == 2) chk("after_rst_first", grants[0], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
